img_stream_ctrl: RTL and testbench

IMG_STREAM_CTRL -- requirements
Module: img_stream_ctrl

---
 rtl/img_stream_ctrl_pkg.sv | 28 ++
 rtl/img_stream_ctrl_if.sv | 33 +++
 rtl/img_stream_ctrl_skid_buf.sv | 79 +++++++
 rtl/img_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_img_stream_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_stream_ctrl_pkg.sv
// Shared definitions for the image streaming controller.
//   state_t     : controller FSM encoding (IDLE=0, STREAM=1, DRAIN=2)
//   PIX_W       : pixel width in bits
//   pix_t       : pixel plus frame markers carried through the skid buffer
//   safe_clog2  : counter width helper that never returns 0
package img_stream_ctrl_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_t;

    // A 1-wide or 1-high image still needs a 1-bit counter.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img_stream_ctrl_if.sv
// ROM read port and pixel stream port of img_stream_ctrl.
//   master : the controller (drives rom_en/rom_addr and the m_* stream)
//   slave  : the environment (returns rom_data, drives m_ready)
interface img_stream_ctrl_if #(
    parameter int ADDR_W = 14
);
    import img_stream_ctrl_pkg::*;

    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic              m_valid;
    logic              m_ready;
    logic [PIX_W-1:0]  m_data;
    logic              m_sof;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output rom_en, rom_addr,
        input  rom_data,
        output m_valid, m_data, m_sof, m_eol, m_eof,
        input  m_ready
    );

    modport slave (
        input  rom_en, rom_addr,
        output rom_data,
        input  m_valid, m_data, m_sof, m_eol, m_eof,
        output m_ready
    );

endinterface

// File: rtl/img_stream_ctrl_skid_buf.sv
// Two-entry fall-through skid buffer for pixels read from the ROM.
// When empty, the incoming word is presented combinationally on the output so
// a ROM read reaches the stream in the same cycle its data appears; any word
// not accepted is captured and held stable until the consumer takes it.
//   clk, rst    : clock, synchronous active-high reset
//   i_flush     : drop all contents (including the word arriving this cycle)
//   i_s_valid / o_s_ready / i_s_data : upstream side
//   o_m_valid / i_m_ready / o_m_data : downstream side (data zero when idle)
//   o_count     : number of words held in storage
module skid_buf
    import img_stream_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    input  pix_t       i_s_data,
    output logic       o_m_valid,
    input  logic       i_m_ready,
    output pix_t       o_m_data,
    output logic [1:0] o_count
);

    pix_t       r_mem0;   // head
    pix_t       r_mem1;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign o_s_ready = (r_cnt != 2'd2);
    assign o_m_valid = (r_cnt != 2'd0) || i_s_valid;
    assign o_count   = r_cnt;
    assign w_push    = i_s_valid && o_s_ready;
    assign w_pop     = o_m_valid && i_m_ready;

    always_comb begin
        o_m_data = '0;
        if (r_cnt != 2'd0)
            o_m_data = r_mem0;
        else if (i_s_valid)
            o_m_data = i_s_data;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_cnt  <= 2'd0;
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    // push+pop while empty is a pure pass-through
                    if (w_push && !w_pop) begin
                        r_mem0 <= i_s_data;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_mem0 <= i_s_data;
                    end else if (w_push) begin
                        r_mem1 <= i_s_data;
                        r_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt  <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_mem0 <= r_mem1;
                        r_cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/img_stream_ctrl.sv
// Image streaming controller: reads a WIDTH x HEIGHT image from a 1-cycle
// latency ROM in row-major order and streams it out over valid/ready with
// start-of-frame, end-of-line and end-of-frame markers.
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : frame request (IDLE only), frame termination
//   busy, done    : not-IDLE indicator, end-of-frame / abort pulse
//   bus (master)  : ROM read port and output pixel stream
module img_stream_ctrl
    import img_stream_ctrl_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int ADDR_W = 14
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    img_stream_ctrl_if.master bus
);

    localparam int XW = safe_clog2(WIDTH);
    localparam int YW = safe_clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    // Read issued last cycle: its data is on rom_data this cycle.
    logic              r_inf_vld;
    logic              r_inf_sof;
    logic              r_inf_eol;
    logic              r_inf_eof;

    logic [1:0]        w_occ;
    logic [1:0]        w_outstanding;
    logic              w_issue;
    logic              w_sof;
    logic              w_eol;
    logic              w_eof;
    pix_t              w_in;
    pix_t              w_out;
    logic              w_out_vld;
    logic              w_in_rdy;
    logic              w_xfer_last;

    // Never let stored + in-flight pixels exceed the two buffer slots, so a
    // returning ROM word always has somewhere to land.
    assign w_outstanding = w_occ + {1'b0, r_inf_vld};
    assign w_issue       = (r_state == ST_STREAM) && (w_outstanding < 2'd2);

    // Markers are decided when the address is issued and ride with the data.
    assign w_sof = (r_x == '0) && (r_y == '0);
    assign w_eol = (r_x == X_LAST);
    assign w_eof = w_eol && (r_y == Y_LAST);

    assign w_in = {bus.rom_data, r_inf_sof, r_inf_eol, r_inf_eof};

    skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (abort),
        .i_s_valid (r_inf_vld),
        .o_s_ready (w_in_rdy),
        .i_s_data  (w_in),
        .o_m_valid (w_out_vld),
        .i_m_ready (bus.m_ready),
        .o_m_data  (w_out),
        .o_count   (w_occ)
    );

    assign bus.rom_en   = w_issue;
    assign bus.rom_addr = r_addr;
    assign bus.m_valid  = w_out_vld;
    assign bus.m_data   = w_out.data;
    assign bus.m_sof    = w_out.sof;
    assign bus.m_eol    = w_out.eol;
    assign bus.m_eof    = w_out.eof;

    assign busy        = (r_state != ST_IDLE);
    assign w_xfer_last = (r_state == ST_DRAIN) && w_out_vld && bus.m_ready && w_out.eof;
    // Pulses in the cycle of the final handshake, or of an abort while busy.
    assign done        = !rst && ((abort && busy) || w_xfer_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_inf_vld <= 1'b0;
            r_inf_sof <= 1'b0;
            r_inf_eol <= 1'b0;
            r_inf_eof <= 1'b0;
        end else begin
            r_inf_vld <= w_issue && !abort;
            if (w_issue) begin
                r_inf_sof <= w_sof;
                r_inf_eol <= w_eol;
                r_inf_eof <= w_eof;
            end
            if (abort) begin
                r_state <= ST_IDLE;
                r_addr  <= '0;
                r_x     <= '0;
                r_y     <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start)
                            r_state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (w_issue) begin
                            // Address holds at the last pixel, so a full
                            // 2**ADDR_W image never wraps.
                            if (w_eof) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_addr <= r_addr + 1'b1;
                                if (w_eol) begin
                                    r_x <= '0;
                                    r_y <= r_y + 1'b1;
                                end else begin
                                    r_x <= r_x + 1'b1;
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_xfer_last) begin
                            r_state <= ST_IDLE;
                            r_addr  <= '0;
                            r_x     <= '0;
                            r_y     <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_img_stream_ctrl.sv
// Self-checking bench for img_stream_ctrl: a 4x2 instance and a 1x1 instance
// share one clock. The behavioural ROM returns its address one cycle after
// rom_en (random junk otherwise). Expected pixels come from a queue built from
// the frame rules: pixel i has data i, sof at i==0, eol when i%W==W-1, eof at
// the last index. Inputs change 1 time unit after posedge; outputs are sampled
// on negedge.
module tb_img_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, busy, done;
    logic start1, abort1, busy1, done1;
    int   checks = 0;
    int   errors = 0;

    img_stream_ctrl_if #(.ADDR_W(14)) b4 ();
    img_stream_ctrl_if #(.ADDR_W(14)) b1 ();

    img_stream_ctrl #(.WIDTH(4), .HEIGHT(2), .ADDR_W(14)) u4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .bus(b4.master));

    img_stream_ctrl #(.WIDTH(1), .HEIGHT(1), .ADDR_W(14)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .bus(b1.master));

    always @(posedge clk) begin
        b4.rom_data <= b4.rom_en ? b4.rom_addr[7:0] : 8'($urandom);
        b1.rom_data <= b1.rom_en ? b1.rom_addr[7:0] : 8'($urandom);
    end

    function automatic logic [10:0] model_pix(input int i, input int w, input int h);
        logic [7:0] d;
        d = 8'(i);
        return {d, 1'(i == 0), 1'(i % w == w - 1), 1'(i == w * h - 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        b4.m_ready = 1'b0; b1.m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({b4.rom_en, b4.rom_addr, b4.m_valid, b4.m_data} !== '0) begin
            errors++;
            $display("FAIL reset_bus4 got en=%b addr=%0d v=%b d=%h need all 0",
                     b4.rom_en, b4.rom_addr, b4.m_valid, b4.m_data);
        end
        checks++;
        if ({b4.m_sof, b4.m_eol, b4.m_eof, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags4 got %b need 00000",
                     {b4.m_sof, b4.m_eol, b4.m_eof, busy, done});
        end
        checks++;
        if ({b1.rom_en, b1.m_valid, b1.m_data, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_1x1 got en=%b v=%b d=%h busy=%b done=%b need 0",
                     b1.rom_en, b1.m_valid, b1.m_data, busy1, done1);
        end
        tick();
    endtask

    // Full-rate frame: pixels 0..7 at start+2..start+9, done with the last one.
    task automatic test_stream();
        logic [10:0] q[$];
        logic [10:0] obs, expv;
        for (int i = 0; i < 8; i++) q.push_back(model_pix(i, 4, 2));
        b4.m_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            obs = {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof};
            checks++;
            if (b4.m_valid !== (k >= 2 && k <= 9)) begin
                errors++;
                $display("FAIL stream_valid k=%0d got %b need %b", k, b4.m_valid, (k >= 2 && k <= 9));
            end
            if (k >= 2 && k <= 9 && q.size() > 0) begin
                expv = q.pop_front();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL stream_pixel k=%0d got %h need %h", k, obs, expv);
                end
            end
            checks++;
            if (done !== (k == 9)) begin
                errors++;
                $display("FAIL stream_done k=%0d got %b need %b", k, done, (k == 9));
            end
            checks++;
            if (busy !== (k >= 1 && k <= 9)) begin
                errors++;
                $display("FAIL stream_busy k=%0d got %b need %b", k, busy, (k >= 1 && k <= 9));
            end
            if (k == 1) begin
                checks++;
                if (b4.rom_en !== 1'b1 || b4.rom_addr !== 14'd0) begin
                    errors++;
                    $display("FAIL stream_first_read got en=%b addr=%0d need en=1 addr=0",
                             b4.rom_en, b4.rom_addr);
                end
            end
            tick();
            start = 1'b0;
        end
    endtask

    // mode 0: m_ready 1,0,0,1 repeating; modes 1..3: random m_ready.
    task automatic test_backpressure();
        logic [10:0] q[$];
        logic [10:0] obs, prev, expv;
        logic        prev_stall, xfer_now, fin;
        int          iss, xfer;
        for (int mode = 0; mode < 4; mode++) begin
            q.delete();
            for (int i = 0; i < 8; i++) q.push_back(model_pix(i, 4, 2));
            iss = 0; xfer = 0; prev_stall = 1'b0; fin = 1'b0; prev = '0;
            start = 1'b1;
            b4.m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < 200 && !fin; k++) begin
                @(negedge clk);
                obs = {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof};
                if (prev_stall) begin
                    checks++;
                    if (b4.m_valid !== 1'b1 || obs !== prev) begin
                        errors++;
                        $display("FAIL bp_stable mode=%0d k=%0d got v=%b %h need v=1 %h",
                                 mode, k, b4.m_valid, obs, prev);
                    end
                end
                if (b4.rom_en === 1'b1) iss++;
                xfer_now = b4.m_valid && b4.m_ready;
                if (xfer_now) begin
                    xfer++;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL bp_extra mode=%0d got %h need no pixel", mode, obs);
                    end else begin
                        expv = q.pop_front();
                        if (obs !== expv) begin
                            errors++;
                            $display("FAIL bp_pixel mode=%0d k=%0d got %h need %h", mode, k, obs, expv);
                        end
                    end
                end
                checks++;
                if (iss - xfer > 2) begin
                    errors++;
                    $display("FAIL bp_outstanding mode=%0d k=%0d got %0d need <=2", mode, k, iss - xfer);
                end
                checks++;
                if (done !== (xfer_now && xfer == 8)) begin
                    errors++;
                    $display("FAIL bp_done mode=%0d k=%0d got %b need %b", mode, k, done, (xfer_now && xfer == 8));
                end
                if (done === 1'b1) fin = 1'b1;
                prev_stall = b4.m_valid && !b4.m_ready;
                prev = obs;
                tick();
                start = 1'b0;
                b4.m_ready = (mode == 0) ? 1'((k + 1) % 4 == 0 || (k + 1) % 4 == 3)
                                         : 1'($urandom_range(0, 1));
            end
            checks++;
            if (!fin) begin
                errors++;
                $display("FAIL bp_timeout mode=%0d got no done need done", mode);
            end
            checks++;
            if (xfer != 8 || q.size() != 0) begin
                errors++;
                $display("FAIL bp_count mode=%0d got %0d transfers need 8", mode, xfer);
            end
            b4.m_ready = 1'b0;
            repeat (2) tick();
        end
    endtask

    // 20 stalled cycles: exactly two reads, pixel 0 held; then resume.
    task automatic test_stall();
        logic [10:0] q[$];
        logic [10:0] obs, expv;
        int          iss, xfer;
        logic        fin;
        for (int i = 0; i < 8; i++) q.push_back(model_pix(i, 4, 2));
        iss = 0; xfer = 0; fin = 1'b0;
        b4.m_ready = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            obs = {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof};
            if (k <= 20 && b4.rom_en === 1'b1) iss++;
            if (k >= 2 && k <= 20) begin
                checks++;
                if (b4.m_valid !== 1'b1 || obs !== model_pix(0, 4, 2)) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d got v=%b %h need v=1 %h", k, b4.m_valid, obs, model_pix(0, 4, 2));
                end
            end
            if (k == 20) begin
                checks++;
                if (iss != 2) begin
                    errors++;
                    $display("FAIL stall_reads got %0d need 2", iss);
                end
            end
            if (b4.m_valid && b4.m_ready) begin
                xfer++;
                checks++;
                expv = (q.size() > 0) ? q.pop_front() : 11'h7ff;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL stall_resume k=%0d got %h need %h", k, obs, expv);
                end
            end
            if (done === 1'b1) fin = 1'b1;
            tick();
            start = 1'b0;
            b4.m_ready = (k + 1 > 20);
        end
        checks++;
        if (!fin || xfer != 8) begin
            errors++;
            $display("FAIL stall_finish got done=%b transfers=%0d need done=1 transfers=8", fin, xfer);
        end
        b4.m_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_abort();
        int ndone;
        b4.m_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (b4.m_valid !== 1'b1 || {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof} !== model_pix(3, 4, 2)) begin
                    errors++;
                    $display("FAIL abort_pix3 got %h need %h", {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof}, model_pix(3, 4, 2));
                end
            end
            if (k == 6) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_done got %b need 1", done);
                end
            end
            if (k == 7) begin
                checks++;
                if ({b4.m_valid, busy, done, b4.rom_en} !== 4'b0) begin
                    errors++;
                    $display("FAIL abort_after got v/busy/done/en=%b need 0000", {b4.m_valid, busy, done, b4.rom_en});
                end
            end
            tick();
            start = 1'b0;
            abort = (k + 1 == 6);
            b4.m_ready = (k + 1 != 6);
        end
        // fresh frame after abort
        start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (b4.rom_en !== 1'b1 || b4.rom_addr !== 14'd0) begin
                    errors++;
                    $display("FAIL abort_restart_read got en=%b addr=%0d need en=1 addr=0", b4.rom_en, b4.rom_addr);
                end
            end
            if (k == 2) begin
                checks++;
                if (b4.m_valid !== 1'b1 || {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof} !== model_pix(0, 4, 2)) begin
                    errors++;
                    $display("FAIL abort_restart_pix got v=%b %h need v=1 %h", b4.m_valid,
                             {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof}, model_pix(0, 4, 2));
                end
            end
            if (done === 1'b1) ndone++;
            tick();
            start = 1'b0;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL abort_restart_done got %0d pulses need 1", ndone);
        end
        // start and abort together in IDLE: nothing begins, no done
        start = 1'b1; abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, b4.rom_en, b4.m_valid} !== 4'b0) begin
                errors++;
                $display("FAIL start_abort_idle k=%0d got busy/done/en/v=%b need 0000", k, {busy, done, b4.rom_en, b4.m_valid});
            end
            tick();
            start = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic test_rst_mid();
        int ndone;
        b4.m_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 7) begin
                checks++;
                if (b4.m_valid !== 1'b1 || {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof} !== model_pix(k - 2, 4, 2)) begin
                    errors++;
                    $display("FAIL rst_mid_pix k=%0d got %h need %h", k,
                             {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof}, model_pix(k - 2, 4, 2));
                end
            end
            if (k >= 8) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid_done k=%0d got %b need 0", k, done);
                end
            end
            if (k == 9) begin
                checks++;
                if ({b4.rom_en, b4.rom_addr, b4.m_valid, b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof, busy} !== '0) begin
                    errors++;
                    $display("FAIL rst_mid_zero got en=%b addr=%0d v=%b d=%h flags=%b busy=%b need all 0",
                             b4.rom_en, b4.rom_addr, b4.m_valid, b4.m_data,
                             {b4.m_sof, b4.m_eol, b4.m_eof}, busy);
                end
            end
            tick();
            start = (k + 1 == 4);   // repeated start mid-frame
            rst = (k + 1 == 8);
        end
        start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (b4.rom_en !== 1'b1 || b4.rom_addr !== 14'd0) begin
                    errors++;
                    $display("FAIL rst_restart_read got en=%b addr=%0d need en=1 addr=0", b4.rom_en, b4.rom_addr);
                end
            end
            if (k == 2) begin
                checks++;
                if ({b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof} !== model_pix(0, 4, 2)) begin
                    errors++;
                    $display("FAIL rst_restart_pix got %h need %h", {b4.m_data, b4.m_sof, b4.m_eol, b4.m_eof}, model_pix(0, 4, 2));
                end
            end
            if (done === 1'b1) ndone++;
            tick();
            start = 1'b0;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL rst_restart_done got %0d pulses need 1", ndone);
        end
    endtask

    // 1x1 frame: single pixel carries sof, eol and eof; done with its handshake.
    task automatic test_1x1();
        for (int rep = 0; rep < 2; rep++) begin
            b1.m_ready = (rep == 0);
            start1 = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    checks++;
                    if (b1.rom_en !== 1'b1 || b1.rom_addr !== 14'd0 || busy1 !== 1'b1) begin
                        errors++;
                        $display("FAIL one_read rep=%0d got en=%b addr=%0d busy=%b need 1/0/1", rep, b1.rom_en, b1.rom_addr, busy1);
                    end
                end
                if (k >= 2) begin
                    checks++;
                    if (b1.m_valid !== (rep == 0 ? k == 2 : k <= 5) ||
                        (b1.m_valid && {b1.m_data, b1.m_sof, b1.m_eol, b1.m_eof} !== model_pix(0, 1, 1))) begin
                        errors++;
                        $display("FAIL one_pix rep=%0d k=%0d got v=%b %h need %h", rep, k, b1.m_valid,
                                 {b1.m_data, b1.m_sof, b1.m_eol, b1.m_eof}, model_pix(0, 1, 1));
                    end
                    checks++;
                    if (done1 !== (rep == 0 ? k == 2 : k == 5)) begin
                        errors++;
                        $display("FAIL one_done rep=%0d k=%0d got %b", rep, k, done1);
                    end
                end
                tick();
                start1 = 1'b0;
                if (rep == 1) b1.m_ready = (k + 1 >= 5);
            end
            checks++;
            if (busy1 !== 1'b0) begin
                errors++;
                $display("FAIL one_idle rep=%0d got busy=%b need 0", rep, busy1);
            end
        end
        b1.m_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_abort();
        test_rst_mid();
        test_1x1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
